// File: rtl/bsg_manycore_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : bsg_manycore_store_responder
// Brief    : Network endpoint that turns remote-store packets into local
//            memory writes and returns one credit packet per consumed packet.
// Revision : 1.0
// ============================================================================
module bsg_manycore_store_responder #(
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int data_width_p     = 32,
    parameter int addr_width_p     = 32,
    parameter int mem_addr_width_p = 10,
    parameter int fifo_els_p       = 2,
    localparam int packet_width_lp     = 6 + 2*(x_cord_width_p+y_cord_width_p) + data_width_p + addr_width_p,
    localparam int ret_packet_width_lp = x_cord_width_p + y_cord_width_p + 5
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic [packet_width_lp-1:0]     data_i,
    output logic                           ready_o,
    output logic                           ret_v_o,
    output logic [ret_packet_width_lp-1:0] ret_data_o,
    input  logic                           ret_ready_i,
    output logic                           mem_v_o,
    output logic [mem_addr_width_p-1:0]    mem_addr_o,
    output logic [data_width_p-1:0]        mem_data_o,
    output logic [data_width_p/8-1:0]      mem_mask_o,
    input  logic                           mem_yumi_i,
    output logic [15:0]                    store_cnt_o,
    output logic [15:0]                    drop_cnt_o
);
    localparam int c_from_w  = x_cord_width_p + y_cord_width_p;
    localparam int c_entry_w = packet_width_lp - c_from_w;
    localparam int c_mask_w  = data_width_p / 8;
    localparam int c_ptr_w   = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int c_cnt_w   = $clog2(fifo_els_p + 1);
    localparam int c_hi_lsb  = 2 + mem_addr_width_p;
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(fifo_els_p - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(fifo_els_p);

    typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, RET = 2'd2} state_e;

    // Destination coordinates are never needed once the packet has arrived,
    // so only {op, addr, data, from} is buffered.
    logic [c_entry_w-1:0] r_mem [fifo_els_p];
    logic [c_ptr_w-1:0]   r_rd_ptr, r_wr_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_push, w_pop, w_full, w_head_v;
    logic [c_entry_w-1:0] w_head;

    assign w_full   = (r_count == c_full_cnt);
    assign w_head_v = (r_count != '0);
    assign w_head   = r_mem[r_rd_ptr];
    assign ready_o  = reset_i & (~w_full | w_pop);
    assign w_push   = v_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= data_i[packet_width_lp-1:c_from_w];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    logic [5:0]              w_op;
    logic [addr_width_p-1:0] w_addr;
    logic [data_width_p-1:0] w_data;
    logic [c_from_w-1:0]     w_from;
    logic [c_mask_w-1:0]     w_mask;
    logic                    w_range_err, w_head_store;

    assign w_from = w_head[0 +: c_from_w];
    assign w_data = w_head[c_from_w +: data_width_p];
    assign w_addr = w_head[c_from_w+data_width_p +: addr_width_p];
    assign w_op   = w_head[c_from_w+data_width_p+addr_width_p +: 6];
    // Zero-extends the 4-bit byte mask onto wide words, truncates onto narrow ones.
    assign w_mask = c_mask_w'(w_op[5:2]);

    generate
        if (c_hi_lsb < addr_width_p) begin : g_range
            assign w_range_err = |w_addr[addr_width_p-1:c_hi_lsb];
        end else begin : g_no_range
            assign w_range_err = 1'b0;
        end
    endgenerate

    assign w_head_store = (w_op[1:0] == 2'b01) & ~w_range_err;

    logic w_unused;
    assign w_unused = &{1'b0, data_i[c_from_w-1:0], w_addr[1:0]};

    state_e r_state, w_state_n;
    logic   w_store_done;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= IDLE;
        else          r_state <= w_state_n;
    end

    // Popping from RET lets the next packet start without an IDLE bubble.
    always_comb begin
        w_state_n    = r_state;
        w_pop        = 1'b0;
        w_store_done = 1'b0;
        mem_v_o      = 1'b0;
        ret_v_o      = 1'b0;
        case (r_state)
            IDLE: w_pop = w_head_v;
            WRITE: begin
                mem_v_o = 1'b1;
                if (mem_yumi_i) begin
                    w_store_done = 1'b1;
                    w_state_n    = RET;
                end
            end
            RET: begin
                ret_v_o = 1'b1;
                if (ret_ready_i) begin
                    w_pop     = w_head_v;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
        if (w_pop) w_state_n = w_head_store ? WRITE : RET;
    end

    logic [mem_addr_width_p-1:0] r_addr;
    logic [data_width_p-1:0]     r_data;
    logic [c_mask_w-1:0]         r_mask;
    logic [c_from_w-1:0]         r_from;
    logic [15:0]                 r_store_cnt, r_drop_cnt;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_from      <= '0;
            r_store_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_pop) begin
                r_addr <= w_addr[2 +: mem_addr_width_p];
                r_data <= w_data;
                r_mask <= w_mask;
                r_from <= w_from;
            end
            if (w_store_done && (r_store_cnt != 16'hFFFF)) r_store_cnt <= r_store_cnt + 16'd1;
            if (w_pop && !w_head_store && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign mem_mask_o  = r_mask;
    assign ret_data_o  = {5'b0, r_from};
    assign store_cnt_o = r_store_cnt;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bsg_manycore_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_manycore_store_responder
// Brief    : Directed self-checking bench for the store responder.
// Revision : 1.0
// ============================================================================
module tb_bsg_manycore_store_responder;
    localparam int XW = 4;
    localparam int YW = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 10;
    localparam int PW = 6 + 2*(XW+YW) + DW + AW;
    localparam int RW = XW + YW + 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          v_i;
    logic [PW-1:0] data_i;
    logic          ready_o;
    logic          ret_v_o;
    logic [RW-1:0] ret_data_o;
    logic          ret_ready_i;
    logic          mem_v_o;
    logic [MW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic [DW/8-1:0] mem_mask_o;
    logic          mem_yumi_i;
    logic [15:0]   store_cnt_o;
    logic [15:0]   drop_cnt_o;

    int total = 0;
    int bad   = 0;
    int exp_store = 0;
    int exp_drop  = 0;

    always #5 clk_i = ~clk_i;

    bsg_manycore_store_responder #(
        .x_cord_width_p(XW), .y_cord_width_p(YW), .data_width_p(DW),
        .addr_width_p(AW), .mem_addr_width_p(MW), .fifo_els_p(2)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .ret_v_o(ret_v_o), .ret_data_o(ret_data_o), .ret_ready_i(ret_ready_i),
        .mem_v_o(mem_v_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_mask_o(mem_mask_o), .mem_yumi_i(mem_yumi_i),
        .store_cnt_o(store_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    // Destination cords are set nonzero to show they are ignored.
    function automatic logic [PW-1:0] mk(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] fx,
                                         input logic [3:0] fy);
        return {op, a, d, fy, fx, 4'd7, 4'd3};
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk_i);
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        total++; if ({mem_v_o, ret_v_o} !== 2'b00) begin bad++; $display("FAIL reset_valids got=%b exp=00", {mem_v_o, ret_v_o}); end
        total++; if ({store_cnt_o, drop_cnt_o} !== 32'h0) begin bad++; $display("FAIL reset_counts got=%h exp=0", {store_cnt_o, drop_cnt_o}); end
        reset_i = 1'b1;
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_single_store;
        @(negedge clk_i);
        mem_yumi_i = 1'b1; ret_ready_i = 1'b1;
        v_i = 1'b1; data_i = mk(6'h3D, 32'h40, 32'hDEADBEEF, 4'd1, 4'd2);
        #1;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL single_ready got=%b exp=1", ready_o); end
        @(negedge clk_i); v_i = 1'b0;
        total++; if ({mem_v_o, ret_v_o} !== 2'b00) begin bad++; $display("FAIL single_c1 got=%b exp=00", {mem_v_o, ret_v_o}); end
        @(negedge clk_i);
        total++;
        if ({mem_v_o, ret_v_o, mem_addr_o, mem_mask_o, mem_data_o} !== {2'b10, 10'h010, 4'hF, 32'hDEADBEEF}) begin
            bad++; $display("FAIL single_write got v=%b r=%b a=%h m=%h d=%h exp v=1 r=0 a=010 m=f d=deadbeef",
                            mem_v_o, ret_v_o, mem_addr_o, mem_mask_o, mem_data_o);
        end
        @(negedge clk_i);
        total++;
        if ({ret_v_o, mem_v_o, ret_data_o} !== {2'b10, 13'h021}) begin
            bad++; $display("FAIL single_ret got r=%b v=%b data=%h exp r=1 v=0 data=021", ret_v_o, mem_v_o, ret_data_o);
        end
        exp_store++;
        total++; if (store_cnt_o !== 16'(exp_store)) begin bad++; $display("FAIL single_cnt got=%0d exp=%0d", store_cnt_o, exp_store); end
        @(negedge clk_i);
        total++; if ({mem_v_o, ret_v_o} !== 2'b00) begin bad++; $display("FAIL single_idle got=%b exp=00", {mem_v_o, ret_v_o}); end
    endtask

    task automatic test_backpressure;
        @(negedge clk_i);
        mem_yumi_i = 1'b0; ret_ready_i = 1'b1;
        v_i = 1'b1; data_i = mk(6'h3D, 32'h80, 32'h11111111, 4'd3, 4'd4);
        @(negedge clk_i); v_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            total++;
            if ({mem_v_o, ret_v_o, mem_addr_o, mem_mask_o, mem_data_o} !== {2'b10, 10'h020, 4'hF, 32'h11111111}) begin
                bad++; $display("FAIL bp_write_hold[%0d] got v=%b r=%b a=%h d=%h exp v=1 r=0 a=020 d=11111111",
                                i, mem_v_o, ret_v_o, mem_addr_o, mem_data_o);
            end
            if (i == 2) begin
                total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", ready_o); end
            end
            case (i)
                0: begin v_i = 1'b1; data_i = mk(6'h3D, 32'h84, 32'h22222222, 4'd5, 4'd6); end
                1: data_i = mk(6'h3D, 32'h88, 32'h33333333, 4'd7, 4'd8);
                2: v_i = 1'b0;
                4: begin mem_yumi_i = 1'b1; ret_ready_i = 1'b0; end
                default: ;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            total++;
            if ({ret_v_o, mem_v_o, ready_o, ret_data_o} !== {3'b100, 13'h043}) begin
                bad++; $display("FAIL bp_ret_hold[%0d] got r=%b v=%b rdy=%b data=%h exp r=1 v=0 rdy=0 data=043",
                                i, ret_v_o, mem_v_o, ready_o, ret_data_o);
            end
        end
        @(negedge clk_i);
        ret_ready_i = 1'b1;
        #1;
        total++; if ({ret_v_o, ready_o} !== 2'b11) begin bad++; $display("FAIL bp_release got r=%b rdy=%b exp 1 1", ret_v_o, ready_o); end
        @(negedge clk_i);
        total++; if ({mem_v_o, mem_addr_o, mem_data_o} !== {1'b1, 10'h021, 32'h22222222}) begin
            bad++; $display("FAIL bp_p2_write got v=%b a=%h d=%h exp v=1 a=021 d=22222222", mem_v_o, mem_addr_o, mem_data_o);
        end
        @(negedge clk_i);
        total++; if ({ret_v_o, mem_v_o, ret_data_o} !== {2'b10, 13'h065}) begin
            bad++; $display("FAIL bp_p2_ret got r=%b v=%b data=%h exp r=1 v=0 data=065", ret_v_o, mem_v_o, ret_data_o);
        end
        @(negedge clk_i);
        total++; if ({mem_v_o, mem_addr_o, mem_data_o} !== {1'b1, 10'h022, 32'h33333333}) begin
            bad++; $display("FAIL bp_p3_write got v=%b a=%h d=%h exp v=1 a=022 d=33333333", mem_v_o, mem_addr_o, mem_data_o);
        end
        @(negedge clk_i);
        total++; if ({ret_v_o, ret_data_o} !== {1'b1, 13'h087}) begin
            bad++; $display("FAIL bp_p3_ret got r=%b data=%h exp r=1 data=087", ret_v_o, ret_data_o);
        end
        @(negedge clk_i);
        exp_store += 3;
        total++; if ({mem_v_o, ret_v_o, store_cnt_o} !== {2'b00, 16'(exp_store)}) begin
            bad++; $display("FAIL bp_end got v=%b r=%b cnt=%0d exp 0 0 %0d", mem_v_o, ret_v_o, store_cnt_o, exp_store);
        end
    endtask

    task automatic test_drop(input string tag, input logic [5:0] op, input logic [31:0] a);
        @(negedge clk_i);
        mem_yumi_i = 1'b1; ret_ready_i = 1'b1;
        v_i = 1'b1; data_i = mk(op, a, 32'hCAFEF00D, 4'd9, 4'd10);
        @(negedge clk_i); v_i = 1'b0;
        total++; if ({mem_v_o, ret_v_o} !== 2'b00) begin bad++; $display("FAIL %s_c1 got=%b exp=00", tag, {mem_v_o, ret_v_o}); end
        @(negedge clk_i);
        exp_drop++;
        total++; if ({ret_v_o, mem_v_o, ret_data_o} !== {2'b10, 13'h0A9}) begin
            bad++; $display("FAIL %s_ret got r=%b v=%b data=%h exp r=1 v=0 data=0a9", tag, ret_v_o, mem_v_o, ret_data_o);
        end
        total++; if ({drop_cnt_o, store_cnt_o} !== {16'(exp_drop), 16'(exp_store)}) begin
            bad++; $display("FAIL %s_cnt got drop=%0d store=%0d exp drop=%0d store=%0d", tag, drop_cnt_o, store_cnt_o, exp_drop, exp_store);
        end
        @(negedge clk_i);
        total++; if ({mem_v_o, ret_v_o} !== 2'b00) begin bad++; $display("FAIL %s_idle got=%b exp=00", tag, {mem_v_o, ret_v_o}); end
    endtask

    task automatic test_streaming;
        logic [PW-1:0] pk [8];
        int sent = 0, nwr = 0, nret = 0, last_wr = 0, cyc = 0;
        for (int i = 0; i < 8; i++)
            pk[i] = mk({4'(i*3), 2'b01}, 32'h100 + 32'(4*i), 32'hA5000000 + 32'(i), 4'(i), 4'(15-i));
        mem_yumi_i = 1'b1; ret_ready_i = 1'b1;
        while (nret < 8 && cyc < 80) begin
            @(negedge clk_i);
            if (mem_v_o) begin
                total++;
                if (nwr >= 8 || {mem_addr_o, mem_data_o, mem_mask_o} !== {10'(32'h40 + nwr), 32'hA5000000 + 32'(nwr), 4'(nwr*3)}) begin
                    bad++; $display("FAIL stream_write[%0d] got a=%h d=%h m=%h", nwr, mem_addr_o, mem_data_o, mem_mask_o);
                end
                if (nwr > 0) begin
                    total++; if (cyc - last_wr != 2) begin bad++; $display("FAIL stream_gap[%0d] got=%0d exp=2", nwr, cyc - last_wr); end
                end
                last_wr = cyc; nwr++;
            end
            if (ret_v_o) begin
                total++;
                if (nret >= 8 || ret_data_o !== {5'b0, 4'(15-nret), 4'(nret)}) begin
                    bad++; $display("FAIL stream_ret[%0d] got=%h", nret, ret_data_o);
                end
                nret++;
            end
            v_i = (sent < 8);
            if (sent < 8) data_i = pk[sent];
            #1;
            if (v_i && ready_o) sent++;
            cyc++;
        end
        v_i = 1'b0;
        exp_store += 8;
        total++; if (nret != 8 || nwr != 8) begin bad++; $display("FAIL stream_count got wr=%0d ret=%0d exp 8 8", nwr, nret); end
        @(negedge clk_i);
        total++; if (store_cnt_o !== 16'(exp_store)) begin bad++; $display("FAIL stream_cnt got=%0d exp=%0d", store_cnt_o, exp_store); end
    endtask

    task automatic test_reset_mid_write;
        @(negedge clk_i);
        mem_yumi_i = 1'b0; ret_ready_i = 1'b1;
        v_i = 1'b1; data_i = mk(6'h3D, 32'h200, 32'h0BADBEEF, 4'd2, 4'd3);
        @(negedge clk_i); v_i = 1'b0;
        @(negedge clk_i);
        total++; if (mem_v_o !== 1'b1) begin bad++; $display("FAIL rst_pre_write got=%b exp=1", mem_v_o); end
        #2 reset_i = 1'b0;
        #1;
        total++; if ({mem_v_o, ret_v_o, ready_o} !== 3'b000) begin bad++; $display("FAIL rst_async got=%b exp=000", {mem_v_o, ret_v_o, ready_o}); end
        total++; if ({store_cnt_o, drop_cnt_o} !== 32'h0) begin bad++; $display("FAIL rst_counts got=%h exp=0", {store_cnt_o, drop_cnt_o}); end
        exp_store = 0; exp_drop = 0;
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        test_single_store();
    endtask

    initial begin
        reset_i = 1'b0; v_i = 1'b0; data_i = '0; ret_ready_i = 1'b0; mem_yumi_i = 1'b0;
        test_reset();
        test_single_store();
        test_backpressure();
        test_drop("range", 6'h3D, 32'h1000);
        test_drop("unknown_op", 6'h02, 32'h40);
        test_streaming();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
